spi_regbank_slave: RTL and testbench
====================================

// Module: spi_regbank_slave
// PURPOSE
//  Parametrised SPI target exposing a config bank (RW) and an independent status bank (RO).
//  Successor to the fixed 8x8 bank: NUM_CFG != NUM_STATUS allowed, all four CPOL/CPHA modes,
//  per-register write strobes, address-error flag, optional burst auto-increment.
//  Sits behind the top-level 2-stage synchronizers; every SPI input is already in the clk domain.
// PARAMETERS
//  NUM_CFG     8     number of RW config registers (1..2**ADDR_WIDTH)
//  NUM_STATUS  12    number of RO status registers (1..2**ADDR_WIDTH)
//  REG_WIDTH   8     bits per register; also the data-phase length
//  ADDR_WIDTH  4     address field width; header HDR_W = ADDR_WIDTH+2
//  RST_VAL     '0    reset value of every config register (REG_WIDTH bits)
// PORTS
//  clk          in   1                    system clock; the only clock
//  rst          in   1                    synchronous active-high reset
//  ena          in   1                    clock enable; 0 freezes all state
//  mode         in   2                    {cpol,cpha}, synchronized; sampled at CS falling edge only
//  spi_cs_n     in   1                    chip select, active low, synchronized
//  spi_clk      in   1                    SCLK, synchronized
//  spi_mosi     in   1                    MOSI, synchronized
//  spi_miso     out  1                    MISO data
//  spi_miso_oe  out  1                    1 while CS is low
//  rw_regs      out  NUM_CFG*REG_WIDTH    config bank; reg i = [i*REG_WIDTH +: REG_WIDTH]
//  ro_regs      in   NUM_STATUS*REG_WIDTH status bank, same packing
//  wr_strobe    out  NUM_CFG              1-cycle pulse on the register just committed
//  addr_err     out  1                    1-cycle pulse on an out-of-range or illegal access
//  busy         out  1                    1 when FSM is not IDLE
// BEHAVIOUR
//  Reset: rw_regs=RST_VAL for all regs; spi_miso=0, wr_strobe=0, addr_err=0, busy=0; FSM=IDLE.
//  Edges: register the previous SCLK value. Leading edge = SCLK leaves level cpol.
//   cpha=0: sample on leading edge, shift on trailing. cpha=1: sample on trailing, shift on leading.
//  Frame, MSB first: header {rw(1=write), space(0=cfg,1=status), addr}, then REG_WIDTH data bits.
//  FSM: IDLE -(CS fall; latch mode)-> HEADER -(HDR_W bits sampled)-> DATA -(REG_WIDTH bits)->
//   DATA (burst, next word) or DRAIN. DRAIN ignores SCLK until CS rises.
//   Any state -(CS high)-> IDLE in the same cycle, overriding every other transition.
//  Read: shadow <= selected register on the cycle of the last header sample.
//   Each shift edge in DATA drives the next shadow bit, starting with the MSB. spi_miso=0 outside DATA.
//  Write: shift MOSI in on sample edges. One cycle after the last data sample edge:
//   reg[addr] <= word and wr_strobe[addr]=1 for one cycle.
//  Illegal access (cfg addr>=NUM_CFG, status addr>=NUM_STATUS, or a write to status):
//   addr_err pulses one cycle after the header completes; writes are discarded; reads return all zeros.
//  CS rising mid-header or mid-data: abort, discard partial word, no strobe, no error.
//  rst mid-frame: immediate IDLE plus full reset. rst takes priority over ena.
//  Sample and shift edges coinciding with CS rise are ignored.
// CONFIGURATION
//  SPI_REGBANK_BURST_EN defined: after each data word the address increments and wraps to 0
//   at NUM_CFG-1 (cfg) or NUM_STATUS-1 (status). Reads reload the shadow at word end. Range is re-checked each word.
//  Not defined: exactly one word per frame; DATA -> DRAIN; further bits ignored; MISO=0 during DRAIN.
// STRUCTURE
//  Package spi_regbank_pkg: state_t enum {IDLE,HEADER,DATA,DRAIN}; header bit-position localparams
//   (RW_BIT, SPACE_BIT); bit-counter width function.
//  Sub-module spi_sclk_edge: mode latch + SCLK history -> sample_p/shift_p pulses.
//  Top holds the FSM, bit counter, shift registers, register bank and decode.
// TESTING (defaults; ro_regs[7:0]=0xCA, ro_regs[15:8]=0x10)
//  1 Mode0 write header 1_0_0010 + 0xA5 -> rw_regs[23:16]=0xA5; wr_strobe=8'h04 one cycle.
//  2 Mode3 read header 0_1_0000 -> MISO data bits 1,1,0,0,1,0,1,0 (0xCA); spi_miso_oe=1 only while CS low.
//  3 BURST_EN, mode1, write cfg addr 7 with 0x11,0x22,0x33 -> regs 7=0x11, 0=0x22, 1=0x33 (wrap);
//    without the macro -> only reg7=0x11.
//  4 Mode2 write addr 3, CS raised after 4 data bits -> reg3 stays RST_VAL; no wr_strobe, no addr_err.
//  5 Read cfg addr 9 -> MISO 0x00, addr_err pulse. Write status addr 1 -> addr_err; no bank change.
//  6 rst asserted mid-data -> all regs RST_VAL, busy=0. Hold ena=0 during SCLK edges -> no state change.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared types, header field positions and sizing helper for the SPI register bank
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        DRAIN
    } state_t;

    // Header is {rw, space, addr}; these are bit offsets above the address field
    localparam int RW_BIT    = 1;
    localparam int SPACE_BIT = 0;

    // Width of a counter that must reach n-1
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sclk_edge.sv
// rtl/spi_sclk_edge.sv - mode latch and SCLK history producing sample/shift pulses
module spi_sclk_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] mode,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    output logic       cs_fall,
    output logic       sample_p,
    output logic       shift_p
);

    logic       cs_q;
    logic       sclk_q;
    logic [1:0] mode_q;
    logic       cpol;
    logic       cpha;
    logic       leading;
    logic       trailing;

    // Track CS and SCLK history; capture {cpol,cpha} only when CS falls.
    // cs_q resets low so a frame already in flight at reset is not mistaken for a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= 1'b0;
            sclk_q <= spi_clk;
            mode_q <= 2'b00;
        end else if (ena) begin
            cs_q   <= spi_cs_n;
            sclk_q <= spi_clk;
            if (cs_q && !spi_cs_n) begin
                mode_q <= mode;
            end
        end
    end

    // Leading edge leaves the idle level cpol; trailing edge returns to it
    always_comb begin
        cpol     = mode_q[1];
        cpha     = mode_q[0];
        leading  = (sclk_q == cpol) && (spi_clk != cpol);
        trailing = (sclk_q != cpol) && (spi_clk == cpol);
        cs_fall  = cs_q && !spi_cs_n;
        sample_p = !spi_cs_n && (cpha ? trailing : leading);
        shift_p  = !spi_cs_n && (cpha ? leading : trailing);
    end

endmodule

// File: rtl/spi_regbank_slave.sv
// rtl/spi_regbank_slave.sv - SPI target with RW config bank and RO status bank; SPI_REGBANK_BURST_EN enables burst auto-increment
module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int                   NUM_CFG    = 8,
    parameter int                   NUM_STATUS = 12,
    parameter int                   REG_WIDTH  = 8,
    parameter int                   ADDR_WIDTH = 4,
    parameter logic [REG_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic                            spi_miso_oe,
    output logic [NUM_CFG*REG_WIDTH-1:0]    rw_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] ro_regs,
    output logic [NUM_CFG-1:0]              wr_strobe,
    output logic                            addr_err,
    output logic                            busy
);

    localparam int HDR_W   = ADDR_WIDTH + 2;
    localparam int CNT_W   = cnt_width((HDR_W > REG_WIDTH) ? HDR_W : REG_WIDTH);
    localparam int CFG_N_I  = NUM_CFG;
    localparam int STAT_N_I = NUM_STATUS;
    localparam int CFG_L_I  = NUM_CFG - 1;
    localparam int STAT_L_I = NUM_STATUS - 1;
    localparam logic [ADDR_WIDTH:0] CFG_CNT   = CFG_N_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] STAT_CNT  = STAT_N_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CFG_LAST  = CFG_L_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] STAT_LAST = STAT_L_I[ADDR_WIDTH:0];

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [HDR_W-2:0]        hdr_sr;
    logic [REG_WIDTH-2:0]    rx_sr;
    logic [REG_WIDTH-1:0]    tx_sr;
    logic                    rw_q;
    logic                    space_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [REG_WIDTH-1:0]    cfg_q [NUM_CFG];

    logic                    cs_fall;
    logic                    sample_p;
    logic                    shift_p;
    logic [HDR_W-1:0]        hdr_next;
    logic [REG_WIDTH-1:0]    word_next;
    logic                    hdr_done;
    logic                    word_done;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic                    sel_rw;
    logic                    sel_space;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_illegal;
    logic [REG_WIDTH-1:0]    rd_word;

    spi_sclk_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .mode     (mode),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .cs_fall  (cs_fall),
        .sample_p (sample_p),
        .shift_p  (shift_p)
    );

    assign spi_miso_oe = !spi_cs_n;
    assign busy        = (state != IDLE);

    // Frame progress decode and next-address arithmetic (wrap at the bank's last register)
    always_comb begin
        hdr_next  = {hdr_sr, spi_mosi};
        word_next = {rx_sr, spi_mosi};
        hdr_done  = (state == HEADER) && sample_p && (bit_cnt == CNT_W'(HDR_W - 1));
        word_done = (state == DATA) && sample_p && (bit_cnt == CNT_W'(REG_WIDTH - 1));
        commit    = word_done && rw_q && !err_q;
        if (space_q ? ({1'b0, addr_q} == STAT_LAST) : ({1'b0, addr_q} == CFG_LAST)) begin
            addr_inc = '0;
        end else begin
            addr_inc = addr_q + 1'b1;
        end
    end

    // Select the access being set up: the fresh header, or the next burst word
    always_comb begin
        if (state == HEADER) begin
            sel_rw    = hdr_next[ADDR_WIDTH + RW_BIT];
            sel_space = hdr_next[ADDR_WIDTH + SPACE_BIT];
            sel_addr  = hdr_next[ADDR_WIDTH-1:0];
        end else begin
            sel_rw    = rw_q;
            sel_space = space_q;
            sel_addr  = addr_inc;
        end
        sel_illegal = sel_space ? (sel_rw || ({1'b0, sel_addr} >= STAT_CNT))
                                : ({1'b0, sel_addr} >= CFG_CNT);
    end

    // Read mux; illegal accesses read back as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (!sel_space && (sel_addr == ADDR_WIDTH'(i))) begin
                rd_word = cfg_q[i];
            end
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (sel_space && (sel_addr == ADDR_WIDTH'(i))) begin
                rd_word = ro_regs[i*REG_WIDTH +: REG_WIDTH];
            end
        end
        if (sel_illegal) begin
            rd_word = '0;
        end
    end

    // Frame FSM: header capture, data shifting, MISO drive and error pulse; CS high aborts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            hdr_sr   <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            rw_q     <= 1'b0;
            space_q  <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            spi_miso <= 1'b0;
            addr_err <= 1'b0;
        end else if (ena) begin
            addr_err <= 1'b0;
            if (spi_cs_n) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= HEADER;
                            bit_cnt <= '0;
                        end
                    end
                    HEADER: begin
                        if (sample_p) begin
                            hdr_sr  <= hdr_next[HDR_W-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (hdr_done) begin
                                state    <= DATA;
                                bit_cnt  <= '0;
                                rw_q     <= sel_rw;
                                space_q  <= sel_space;
                                addr_q   <= sel_addr;
                                err_q    <= sel_illegal;
                                addr_err <= sel_illegal;
                                tx_sr    <= rd_word;
                            end
                        end
                    end
                    DATA: begin
                        if (shift_p) begin
                            spi_miso <= tx_sr[REG_WIDTH-1];
                            tx_sr    <= {tx_sr[REG_WIDTH-2:0], 1'b0};
                        end
                        if (sample_p) begin
                            rx_sr   <= word_next[REG_WIDTH-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (word_done) begin
                                bit_cnt <= '0;
`ifdef SPI_REGBANK_BURST_EN
                                addr_q   <= addr_inc;
                                err_q    <= sel_illegal;
                                addr_err <= sel_illegal;
                                tx_sr    <= rd_word;
`else
                                state    <= DRAIN;
                                spi_miso <= 1'b0;
`endif
                            end
                        end
                    end
                    DRAIN: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Config bank: commit the completed word and pulse its strobe
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rst) begin
                cfg_q[i]     <= RST_VAL;
                wr_strobe[i] <= 1'b0;
            end else if (ena) begin
                wr_strobe[i] <= commit && (addr_q == ADDR_WIDTH'(i));
                if (commit && (addr_q == ADDR_WIDTH'(i))) begin
                    cfg_q[i] <= word_next;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_pack
        assign rw_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
    end

endmodule

// File: tb/tb_spi_regbank_slave.sv
// tb/tb_spi_regbank_slave.sv - scoreboard bench for spi_regbank_slave (honours SPI_REGBANK_BURST_EN)
module tb_spi_regbank_slave;

    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [1:0]  mode;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [63:0] rw_regs;
    logic [95:0] ro_regs;
    logic [7:0]  wr_strobe;
    logic        addr_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int frame_id = 0;

    logic [15:0] exp_strb [$];
    int          exp_err  [$];
    logic [7:0]  exp_rd   [$];
    logic [7:0]  obs_rd   [$];
    logic [63:0] model;

    spi_regbank_slave dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .mode        (mode),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rw_regs     (rw_regs),
        .ro_regs     (ro_regs),
        .wr_strobe   (wr_strobe),
        .addr_err    (addr_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe, error pulse or read word
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (|wr_strobe) begin
                if (exp_strb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL strobe_unexpected: got %h want none", wr_strobe);
                end else begin
                    e = exp_strb.pop_front();
                    chk("strobe_mask", {56'd0, wr_strobe}, {56'd0, e[15:8]});
                    for (int i = 0; i < 8; i++) begin
                        if (e[8+i]) chk("strobe_data", {56'd0, rw_regs[i*8 +: 8]}, {56'd0, e[7:0]});
                    end
                end
            end
            if (addr_err === 1'b1) begin
                if (exp_err.size() == 0) begin
                    total++; bad++;
                    $display("FAIL err_unexpected: got pulse in frame %0d want none", frame_id);
                end else begin
                    chk("err_frame", frame_id, exp_err.pop_front());
                end
            end
            if (obs_rd.size() > 0) begin
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got %h want none", obs_rd.pop_front());
                end else begin
                    chk("rd_data", {56'd0, obs_rd.pop_front()}, {56'd0, exp_rd.pop_front()});
                end
            end
        end
    end

    // SPI master: hdr then data MSB first; optional MISO capture, mid-frame reset, ena gap
    task automatic spi_xfer(input logic [1:0] m, input logic [5:0] hdr, input logic [23:0] data,
                            input int nbits, input bit rd_chk, input int rst_bit, input int gap_bit);
        logic       cpol;
        logic       cpha;
        logic [7:0] rd;
        int         nrd;
        cpol = m[1];
        cpha = m[0];
        frame_id++;
        mode     = m;
        spi_clk  = cpol;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("miso_oe_low", {63'd0, spi_miso_oe}, 64'd1);
        nrd = 0;
        rd  = '0;
        for (int b = 0; b < nbits; b++) begin
            logic d;
            if (b < 6) d = hdr[5-b];
            else       d = data[23-(b-6)];
            if (b == rst_bit) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_regs", rw_regs, 64'd0);
            end
            if (b == gap_bit) begin
                ena = 1'b0;
                repeat (3) begin
                    spi_mosi = ~spi_mosi;
                    @(negedge clk);
                    spi_clk = ~cpol;
                    repeat (H) @(negedge clk);
                    spi_clk = cpol;
                    repeat (H) @(negedge clk);
                end
                chk("gap_busy", {63'd0, busy}, 64'd1);
                ena = 1'b1;
                @(negedge clk);
            end
            if (!cpha) begin
                spi_mosi = d;
                repeat (H) @(negedge clk);
            end else begin
                spi_clk  = ~cpol;
                spi_mosi = d;
                repeat (H) @(negedge clk);
            end
            if (rd_chk) begin
                if (b < 6) begin
                    chk("miso_hdr", {63'd0, spi_miso}, 64'd0);
                end else begin
                    rd = {rd[6:0], spi_miso};
                    nrd++;
                    if (nrd == 8) begin
                        obs_rd.push_back(rd);
                        nrd = 0;
                    end
                end
            end
            if (!cpha) begin
                spi_clk = ~cpol;
                repeat (H) @(negedge clk);
                spi_clk = cpol;
            end else begin
                spi_clk = cpol;
                repeat (H) @(negedge clk);
            end
        end
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("miso_oe_high", {63'd0, spi_miso_oe}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        rst      = 1'b1;
        ena      = 1'b1;
        mode     = 2'b00;
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        ro_regs  = '0;
        ro_regs[7:0]  = 8'hCA;
        ro_regs[15:8] = 8'h10;
        model    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rw_regs", rw_regs, 64'd0);
        chk("rst_strobe", {56'd0, wr_strobe}, 64'd0);
        chk("rst_err", {63'd0, addr_err}, 64'd0);
        chk("rst_busy0", {63'd0, busy}, 64'd0);
        chk("rst_miso", {63'd0, spi_miso}, 64'd0);

        // Mode0 write cfg 2 = 0xA5
        exp_strb.push_back({8'h04, 8'hA5});
        model[23:16] = 8'hA5;
        spi_xfer(2'b00, 6'b100010, 24'hA50000, 14, 1'b0, -1, -1);
        chk("t1_reg2", {56'd0, rw_regs[23:16]}, 64'hA5);

        // Readbacks: cfg 2 in mode2, status 0 in mode3, status 1 in mode1
        exp_rd.push_back(8'hA5);
        spi_xfer(2'b10, 6'b000010, 24'h0, 14, 1'b1, -1, -1);
        exp_rd.push_back(8'hCA);
        spi_xfer(2'b11, 6'b010000, 24'h0, 14, 1'b1, -1, -1);
        exp_rd.push_back(8'h10);
        spi_xfer(2'b01, 6'b010001, 24'h0, 14, 1'b1, -1, -1);

        // Mode1 write cfg 7 with three words
`ifdef SPI_REGBANK_BURST_EN
        exp_strb.push_back({8'h80, 8'h11});
        exp_strb.push_back({8'h01, 8'h22});
        exp_strb.push_back({8'h02, 8'h33});
        model[63:56] = 8'h11;
        model[7:0]   = 8'h22;
        model[15:8]  = 8'h33;
`else
        exp_strb.push_back({8'h80, 8'h11});
        model[63:56] = 8'h11;
`endif
        spi_xfer(2'b01, 6'b100111, 24'h112233, 30, 1'b0, -1, -1);
        chk("t3_bank", rw_regs, model);

        // Mode2 write cfg 3 aborted after 4 data bits
        spi_xfer(2'b10, 6'b100011, 24'hFF0000, 10, 1'b0, -1, -1);
        chk("t4_bank", rw_regs, model);

        // Illegal: read cfg 9, write status 1
        exp_rd.push_back(8'h00);
        exp_err.push_back(frame_id + 1);
`ifdef SPI_REGBANK_BURST_EN
        exp_err.push_back(frame_id + 1);
`endif
        spi_xfer(2'b00, 6'b001001, 24'h0, 14, 1'b1, -1, -1);
        exp_err.push_back(frame_id + 1);
`ifdef SPI_REGBANK_BURST_EN
        exp_err.push_back(frame_id + 1);
`endif
        spi_xfer(2'b00, 6'b110001, 24'h5A0000, 14, 1'b0, -1, -1);
        chk("t5_bank", rw_regs, model);

        // Mode0 write cfg 5 = 0x3C with an ena=0 gap of junk SCLK cycles mid-word
        exp_strb.push_back({8'h20, 8'h3C});
        model[47:40] = 8'h3C;
        spi_xfer(2'b00, 6'b100101, 24'h3C0000, 14, 1'b0, -1, 10);
        chk("gap_bank", rw_regs, model);

        // Reset mid-data of a write to cfg 4
        model = '0;
        spi_xfer(2'b00, 6'b100100, 24'hFF0000, 14, 1'b0, 9, -1);
        chk("t6_bank", rw_regs, model);

        repeat (10) @(negedge clk);
        chk("strb_left", exp_strb.size(), 64'd0);
        chk("err_left", exp_err.size(), 64'd0);
        chk("rd_left", exp_rd.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
